// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard detection, operand forwarding, front-end flush and halt drain for the
// in-order core. A DEPTH-entry shadow pipe mirrors the register writes that
// are in flight between decode and writeback (entry 0 = EX ... DEPTH-1 = WB).
// Every decision is taken combinationally from the shadow pipe, the halt FSM
// and the current decode inputs, so the outputs add no latency.
//
// Redirect handshake: i_redirect is a level from EX. The source holds it high
// until it is accepted. It is accepted in any cycle where i_mem_busy is low and
// the core is not HALTED. Acceptance squashes the decode slot: o_flush_if=1 and
// entry 0 takes a bubble. i_mem_busy freezes the whole pipe. While it is high,
// nothing is accepted and nothing issues.

module pipe_hazard_ctrl #(
    parameter int DEPTH      = 3,
    parameter int REG_W      = 3,
    parameter int LOAD_STAGE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_rs_used,
    input  logic             i_id_rt_used,
    input  logic             i_id_wr_en,
    input  logic [REG_W-1:0] i_id_wr_reg,
    input  logic             i_id_is_load,
    input  logic             i_id_halt,
    input  logic             i_redirect,
    input  logic             i_mem_busy,
    output logic             o_stall_id,
    output logic             o_flush_if,
    output logic [DEPTH-1:0] o_fwd_rs,
    output logic [DEPTH-1:0] o_fwd_rt,
    output logic             o_halted,
    output logic             o_err,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    // Shadow pipe: one bit-vector per single-bit field, an array for the index
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_wr_en;
    logic [DEPTH-1:0] r_is_load;
    logic [DEPTH-1:0] r_halt;
    logic [REG_W-1:0] r_reg [DEPTH];

    state_t           r_state;
    logic             r_halted;
    logic             r_err;

    logic [DEPTH-1:0] w_fwd_rs;
    logic [DEPTH-1:0] w_fwd_rt;
    logic             w_lu_rs;
    logic             w_lu_rt;
    logic             w_load_use;
    logic             w_advance;
    logic             w_acc_redirect;
    logic             w_stall;
    logic             w_flush;
    logic             w_issue;
    logic             w_multi_halt;
    logic             w_err_now;

    // Operand A lookup: the youngest matching writer wins. A load that is
    // still too young to supply its data turns the match into a load-use stall.
    always_comb begin
        logic hit;
        hit      = 1'b0;
        w_fwd_rs = '0;
        w_lu_rs  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!hit && r_valid[k] && r_wr_en[k] && (r_reg[k] == i_id_rs)) begin
                hit = 1'b1;
                if (r_is_load[k] && (k < LOAD_STAGE)) begin
                    w_lu_rs = 1'b1;
                end else begin
                    w_fwd_rs[k] = 1'b1;
                end
            end
        end
        if (!(i_id_valid && i_id_rs_used)) begin
            w_fwd_rs = '0;
            w_lu_rs  = 1'b0;
        end
    end

    // Operand B lookup, same rules as operand A
    always_comb begin
        logic hit;
        hit      = 1'b0;
        w_fwd_rt = '0;
        w_lu_rt  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!hit && r_valid[k] && r_wr_en[k] && (r_reg[k] == i_id_rt)) begin
                hit = 1'b1;
                if (r_is_load[k] && (k < LOAD_STAGE)) begin
                    w_lu_rt = 1'b1;
                end else begin
                    w_fwd_rt[k] = 1'b1;
                end
            end
        end
        if (!(i_id_valid && i_id_rt_used)) begin
            w_fwd_rt = '0;
            w_lu_rt  = 1'b0;
        end
    end

    // Detect more than one halt in flight; this can only come from a front-end fault
    always_comb begin
        logic seen;
        seen         = 1'b0;
        w_multi_halt = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_valid[k] && r_halt[k]) begin
                if (seen) begin
                    w_multi_halt = 1'b1;
                end
                seen = 1'b1;
            end
        end
    end

    // Stall, flush and issue decisions
    always_comb begin
        w_load_use     = w_lu_rs | w_lu_rt;
        w_advance      = ~i_mem_busy;
        // A redirect is accepted on the first unfrozen cycle. The redirecting
        // branch is older than anything in decode, so it also squashes the
        // decode slot during a drain.
        w_acc_redirect = i_redirect & ~i_mem_busy & (r_state != S_HALTED);
        // The redirect target must load into PC, so acceptance overrides a load-use stall
        w_stall        = i_mem_busy
                       | (w_load_use & ~w_acc_redirect)
                       | (r_state != S_RUN);
        w_flush        = ~i_mem_busy & (w_acc_redirect | (r_state == S_DRAIN));
        w_issue        = i_id_valid & ~w_stall & ~w_acc_redirect;
        w_err_now      = ((r_state == S_HALTED) & (i_id_valid | i_redirect))
                       | w_multi_halt;
    end

    // Shadow pipe shifts toward writeback whenever memory is not busy
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid   <= '0;
            r_wr_en   <= '0;
            r_is_load <= '0;
            r_halt    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_reg[k] <= '0;
            end
        end else if (w_advance) begin
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k]   <= r_valid[k-1];
                r_wr_en[k]   <= r_wr_en[k-1];
                r_is_load[k] <= r_is_load[k-1];
                r_halt[k]    <= r_halt[k-1];
                r_reg[k]     <= r_reg[k-1];
            end
            r_valid[0]   <= w_issue;
            r_wr_en[0]   <= w_issue & i_id_wr_en;
            r_is_load[0] <= w_issue & i_id_is_load;
            r_halt[0]    <= w_issue & i_id_halt;
            r_reg[0]     <= i_id_wr_reg;
        end
    end

    // Halt FSM with the sticky error flag; HALTED is left only through reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= r_err | w_err_now;
            case (r_state)
                S_RUN: begin
                    if (w_issue && i_id_halt) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The halt retires on the shift that moves it out of the WB entry
                    if (w_advance && r_valid[DEPTH-1] && r_halt[DEPTH-1]) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                S_HALTED: begin
                    r_state <= S_HALTED;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign o_stall_id  = w_stall;
    assign o_flush_if  = w_flush;
    assign o_fwd_rs    = w_fwd_rs;
    assign o_fwd_rt    = w_fwd_rt;
    assign o_halted    = r_halted;
    assign o_err       = r_err | w_err_now;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Directed scenarios plus a randomized run against an instruction-level
// reference model. The model keeps the in-flight instructions as records
// ordered by age and derives the expected outputs from the hazard rules.

module tb_pipe_hazard_ctrl;

    localparam int DEPTH      = 3;
    localparam int REG_W      = 3;
    localparam int LOAD_STAGE = 1;
    localparam int VEC_W      = 2 + 2 * DEPTH + 2;

    // Clock / reset and DUT connections
    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic             id_wr_en;
    logic [REG_W-1:0] id_wr_reg;
    logic             id_is_load;
    logic             id_halt;
    logic             redirect;
    logic             mem_busy;
    logic             stall_id;
    logic             flush_if;
    logic [DEPTH-1:0] fwd_rs;
    logic [DEPTH-1:0] fwd_rt;
    logic             halted;
    logic             err;
    logic [1:0]       dbg_state;

    logic [VEC_W-1:0] dut_vec;
    assign dut_vec = {stall_id, flush_if, fwd_rs, fwd_rt, halted, err};

    pipe_hazard_ctrl #(
        .DEPTH      (DEPTH),
        .REG_W      (REG_W),
        .LOAD_STAGE (LOAD_STAGE)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_id_valid   (id_valid),
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .i_id_rs_used (id_rs_used),
        .i_id_rt_used (id_rt_used),
        .i_id_wr_en   (id_wr_en),
        .i_id_wr_reg  (id_wr_reg),
        .i_id_is_load (id_is_load),
        .i_id_halt    (id_halt),
        .i_redirect   (redirect),
        .i_mem_busy   (mem_busy),
        .o_stall_id   (stall_id),
        .o_flush_if   (flush_if),
        .o_fwd_rs     (fwd_rs),
        .o_fwd_rt     (fwd_rt),
        .o_halted     (halted),
        .o_err        (err),
        .o_dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: in-flight instructions indexed by age (0 = youngest)
    typedef struct packed {
        logic             v;
        logic             wr;
        logic [REG_W-1:0] rd;
        logic             ld;
        logic             h;
    } rec_t;

    rec_t             m_e [DEPTH];
    logic             m_draining;
    logic             m_halted;
    logic             m_err;
    logic             m_acc;
    logic             m_issue;
    logic             m_err_now;
    logic [VEC_W-1:0] m_exp;

    function automatic int youngest(input logic [REG_W-1:0] idx);
        for (int k = 0; k < DEPTH; k++) begin
            if (m_e[k].v && m_e[k].wr && (m_e[k].rd == idx)) return k;
        end
        return -1;
    endfunction

    task automatic model_comb();
        int               ka;
        int               kb;
        int               nh;
        logic             lu;
        logic             st;
        logic             fl;
        logic [DEPTH-1:0] fa;
        logic [DEPTH-1:0] fb;
        fa = '0;
        fb = '0;
        lu = 1'b0;
        ka = (id_valid && id_rs_used) ? youngest(id_rs) : -1;
        kb = (id_valid && id_rt_used) ? youngest(id_rt) : -1;
        if (ka >= 0) begin
            if (m_e[ka].ld && ka < LOAD_STAGE) lu = 1'b1;
            else fa[ka] = 1'b1;
        end
        if (kb >= 0) begin
            if (m_e[kb].ld && kb < LOAD_STAGE) lu = 1'b1;
            else fb[kb] = 1'b1;
        end
        m_acc   = redirect && !mem_busy && !m_halted;
        st      = mem_busy || (lu && !m_acc) || m_draining || m_halted;
        fl      = !mem_busy && (m_acc || m_draining);
        m_issue = id_valid && !st && !m_acc;
        nh = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (m_e[k].v && m_e[k].h) nh++;
        end
        m_err_now = (m_halted && (id_valid || redirect)) || (nh > 1);
        m_exp     = {st, fl, fa, fb, m_halted, m_err || m_err_now};
    endtask

    task automatic model_step();
        logic leaving;
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) m_e[k] = '0;
            m_draining = 1'b0;
            m_halted   = 1'b0;
            m_err      = 1'b0;
            return;
        end
        m_err = m_err || m_err_now;
        if (!mem_busy) begin
            leaving = m_e[DEPTH-1].v && m_e[DEPTH-1].h;
            for (int k = DEPTH - 1; k >= 1; k--) m_e[k] = m_e[k-1];
            m_e[0] = '0;
            if (m_issue) begin
                m_e[0].v  = 1'b1;
                m_e[0].wr = id_wr_en;
                m_e[0].rd = id_wr_reg;
                m_e[0].ld = id_is_load;
                m_e[0].h  = id_halt;
            end
            if (leaving && m_draining) begin
                m_draining = 1'b0;
                m_halted   = 1'b1;
            end
        end
        if (m_issue && id_halt) m_draining = 1'b1;
    endtask

    // Driver tasks
    task automatic tick();
        model_comb();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_op(input logic v, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                          input logic ru, input logic tu, input logic wr,
                          input logic [REG_W-1:0] wd, input logic ld, input logic h);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_rs_used = ru;
        id_rt_used = tu;
        id_wr_en   = wr;
        id_wr_reg  = wd;
        id_is_load = ld;
        id_halt    = h;
    endtask

    task automatic do_reset();
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
        redirect = 1'b0;
        mem_busy = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        do_reset();
        #1;
        model_comb();
        n_total++;
        if (dut_vec !== '0) $display("FAIL reset_outputs got=%b exp=%b", dut_vec, {VEC_W{1'b0}});
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            set_op(1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1, 1, 0, 0, 0, 0);
            #1;
            model_comb();
            n_total++;
            if (stall_id !== 1'b0 || dut_vec !== m_exp)
                $display("FAIL nop_issue[%0d] got=%b exp=%b", i, dut_vec, m_exp);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_forward();
        logic [REG_W-1:0] dst [3];
        logic [DEPTH-1:0] want [3];
        dst[0] = 3'd1; dst[1] = 3'd5; dst[2] = 3'd6;
        want[0] = 3'b001; want[1] = 3'b010; want[2] = 3'b100;
        do_reset();
        for (int gap = 0; gap < 3; gap++) begin
            set_op(1, 0, 0, 0, 0, 1, dst[gap], 0, 0);
            tick();
            for (int b = 0; b < gap; b++) begin
                set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
                tick();
            end
            set_op(1, dst[gap], dst[gap], 1, 1, 1, 3'd2, 0, 0);
            #1;
            model_comb();
            n_total++;
            if (fwd_rs !== want[gap] || fwd_rt !== want[gap] || stall_id !== 1'b0 || dut_vec !== m_exp)
                $display("FAIL forward_gap%0d got=%b exp=%b rs=%b rt=%b", gap, dut_vec, m_exp, fwd_rs, fwd_rt);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_op(1, 0, 0, 0, 0, 1, 3'd3, 1, 0);
        tick();
        set_op(1, 3'd3, 3'd0, 1, 1, 1, 3'd4, 0, 0);
        #1;
        model_comb();
        n_total++;
        if (stall_id !== 1'b1 || fwd_rs !== 3'b000 || dut_vec !== m_exp)
            $display("FAIL load_use_stall got=%b exp=%b", dut_vec, m_exp);
        else n_pass++;
        tick();
        #1;
        model_comb();
        n_total++;
        if (stall_id !== 1'b0 || fwd_rs !== 3'b010 || fwd_rt !== 3'b000 || dut_vec !== m_exp)
            $display("FAIL load_use_resume got=%b exp=%b", dut_vec, m_exp);
        else n_pass++;
        tick();
        // ADD now in EX, bubble behind the load, load in WB
        set_op(1, 3'd4, 3'd3, 1, 1, 0, 0, 0, 0);
        #1;
        model_comb();
        n_total++;
        if (fwd_rs !== 3'b001 || fwd_rt !== 3'b100 || dut_vec !== m_exp)
            $display("FAIL load_use_bubble got=%b exp=%b", dut_vec, m_exp);
        else n_pass++;
        tick();
    endtask

    task automatic test_redirect_load_use();
        do_reset();
        set_op(1, 0, 0, 0, 0, 1, 3'd3, 1, 0);
        tick();
        set_op(1, 3'd3, 3'd0, 1, 0, 1, 3'd4, 0, 0);
        redirect = 1'b1;
        #1;
        model_comb();
        n_total++;
        if (stall_id !== 1'b0 || flush_if !== 1'b1 || err !== 1'b0 || dut_vec !== m_exp)
            $display("FAIL redirect_over_load_use got=%b exp=%b", dut_vec, m_exp);
        else n_pass++;
        tick();
        redirect = 1'b0;
        // The squashed ADD must not appear as a writer of r4
        set_op(1, 3'd3, 3'd4, 1, 1, 0, 0, 0, 0);
        #1;
        model_comb();
        n_total++;
        if (fwd_rs !== 3'b010 || fwd_rt !== 3'b000 || stall_id !== 1'b0 || dut_vec !== m_exp)
            $display("FAIL redirect_bubble got=%b exp=%b", dut_vec, m_exp);
        else n_pass++;
        tick();
    endtask

    task automatic test_mem_busy();
        do_reset();
        set_op(1, 0, 0, 0, 0, 1, 3'd7, 0, 0);
        tick();
        set_op(1, 3'd7, 3'd7, 1, 1, 0, 0, 0, 0);
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            model_comb();
            n_total++;
            if (stall_id !== 1'b1 || flush_if !== 1'b0 || fwd_rs !== 3'b001 || fwd_rt !== 3'b001 ||
                dut_vec !== m_exp)
                $display("FAIL mem_busy_freeze[%0d] got=%b exp=%b", i, dut_vec, m_exp);
            else n_pass++;
            tick();
        end
        mem_busy = 1'b0;
        #1;
        model_comb();
        n_total++;
        if (stall_id !== 1'b0 || fwd_rs !== 3'b001 || dut_vec !== m_exp)
            $display("FAIL mem_busy_release got=%b exp=%b", dut_vec, m_exp);
        else n_pass++;
        tick();
        #1;
        model_comb();
        n_total++;
        if (fwd_rs !== 3'b010 || fwd_rt !== 3'b010 || dut_vec !== m_exp)
            $display("FAIL mem_busy_resume got=%b exp=%b", dut_vec, m_exp);
        else n_pass++;
        tick();
    endtask

    task automatic test_halt();
        do_reset();
        set_op(1, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        model_comb();
        n_total++;
        if (stall_id !== 1'b0 || halted !== 1'b0 || dut_vec !== m_exp)
            $display("FAIL halt_issue got=%b exp=%b", dut_vec, m_exp);
        else n_pass++;
        tick();
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            model_comb();
            n_total++;
            if (stall_id !== 1'b1 || flush_if !== 1'b1 || halted !== 1'b0 || dut_vec !== m_exp)
                $display("FAIL halt_drain[%0d] got=%b exp=%b", i, dut_vec, m_exp);
            else n_pass++;
            tick();
        end
        #1;
        model_comb();
        n_total++;
        if (halted !== 1'b1 || stall_id !== 1'b1 || flush_if !== 1'b0 || err !== 1'b0 || dut_vec !== m_exp)
            $display("FAIL halt_done got=%b exp=%b", dut_vec, m_exp);
        else n_pass++;
        tick();
        set_op(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        model_comb();
        n_total++;
        if (err !== 1'b1 || dut_vec !== m_exp)
            $display("FAIL halt_err_set got=%b exp=%b", dut_vec, m_exp);
        else n_pass++;
        tick();
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        model_comb();
        n_total++;
        if (err !== 1'b1 || halted !== 1'b1 || dut_vec !== m_exp)
            $display("FAIL halt_err_sticky got=%b exp=%b", dut_vec, m_exp);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        model_comb();
        n_total++;
        if (err !== 1'b0 || halted !== 1'b0 || dut_vec !== '0)
            $display("FAIL halt_rst_clear got=%b exp=%b", dut_vec, {VEC_W{1'b0}});
        else n_pass++;
    endtask

    task automatic test_random();
        logic hold;
        do_reset();
        hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (m_halted) begin
                do_reset();
                hold = 1'b0;
            end
            set_op($urandom_range(0, 9) < 7,
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)),
                   $urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0);
            redirect = hold ? 1'b1 : ($urandom_range(0, 9) == 0);
            mem_busy = $urandom_range(0, 99) < 15;
            hold     = redirect && mem_busy;
            #1;
            model_comb();
            n_total++;
            if (dut_vec !== m_exp)
                $display("FAIL random[%0d] got=%b exp=%b", i, dut_vec, m_exp);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
        redirect = 1'b0;
        mem_busy = 1'b0;
        for (int k = 0; k < DEPTH; k++) m_e[k] = '0;
        m_draining = 1'b0;
        m_halted   = 1'b0;
        m_err      = 1'b0;
        @(negedge clk);
        test_reset();
        test_forward();
        test_load_use();
        test_redirect_load_use();
        test_mem_busy();
        test_halt();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
